// File: rtl/gen_linear_part_if.sv
// Handshake and data bundle between an upstream term producer and gen_linear_part.
// master drives operands, terms and out_ready; slave (the reducer) drives the results.
interface gen_linear_part_if;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   a;
  logic [7:0]   b;
  logic [500:0] n;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   s;
  logic [6:0]   cy;

  modport master (
    output in_valid, a, b, n, out_ready,
    input  in_ready, out_valid, s, cy
  );

  modport slave (
    input  in_valid, a, b, n, out_ready,
    output in_ready, out_valid, s, cy
  );
endinterface

// File: rtl/gen_linear_part.sv
// Serial XOR recombination of the 501 CLA AND terms into carries c7..c1 and the 8-bit sum.
// Define LINEAR_PART_CHECK_EN to add a registered a+b reference and the chk_err output.
module gen_linear_part #(
  parameter int CHUNK = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  gen_linear_part_if.slave lp
`ifdef LINEAR_PART_CHECK_EN
  ,
  output logic             chk_err
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REDUCE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
  localparam logic [8:0] CHUNK_W = 9'(CHUNK);

  logic [1:0]   state;
  logic [7:0]   a_reg;
  logic [7:0]   b_reg;
  logic [500:0] n_reg;
  logic [2:0]   grp;
  logic [8:0]   ptr;
  logic         acc;
  logic [7:0]   s_reg;
  logic [6:0]   cy_reg;

  logic [8:0]   remain;
  logic [8:0]   step;
  logic         last_chunk;
  logic         fold;
  logic         grp_carry;
  logic [6:0]   cy_full;
  logic [7:0]   s_next;

  // Groups are contiguous, so the next group always starts right after this end index.
  function automatic logic [8:0] grp_end(input logic [2:0] g);
    case (g)
      3'd0:    return 9'd2;
      3'd1:    return 9'd9;
      3'd2:    return 9'd24;
      3'd3:    return 9'd55;
      3'd4:    return 9'd118;
      3'd5:    return 9'd245;
      default: return 9'd500;
    endcase
  endfunction

  always_comb begin
    remain     = grp_end(grp) - ptr + 9'd1;
    last_chunk = (remain <= CHUNK_W);
    step       = last_chunk ? remain : CHUNK_W;
    fold       = 1'b0;
    // Bits past the group end are masked so a chunk never folds terms of the next group.
    for (int k = 0; k < CHUNK; k++) begin
      if (9'(k) < remain) fold = fold ^ n_reg[ptr + 9'(k)];
    end
    grp_carry    = acc ^ fold;
    cy_full      = cy_reg;
    cy_full[grp] = grp_carry;
    s_next       = a_reg ^ b_reg ^ {cy_full, 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      n_reg  <= '0;
      grp    <= '0;
      ptr    <= '0;
      acc    <= 1'b0;
      s_reg  <= '0;
      cy_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lp.in_valid) begin
            a_reg <= lp.a;
            b_reg <= lp.b;
            n_reg <= lp.n;
            grp   <= '0;
            ptr   <= '0;
            acc   <= 1'b0;
            state <= REDUCE;
          end
        end
        REDUCE: begin
          ptr <= ptr + step;
          if (last_chunk) begin
            cy_reg <= cy_full;
            acc    <= 1'b0;
            if (grp == 3'd6) begin
              s_reg <= s_next;
              state <= DONE;
            end else begin
              grp <= grp + 3'd1;
            end
          end else begin
            acc <= grp_carry;
          end
        end
        DONE: begin
          if (lp.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LINEAR_PART_CHECK_EN
  logic [7:0] ref_sum;

  // The reference sum comes straight from the operands, independent of the supplied terms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_sum <= '0;
      chk_err <= 1'b0;
    end else if (state == IDLE && lp.in_valid) begin
      ref_sum <= lp.a + lp.b;
      chk_err <= 1'b0;
    end else if (state == REDUCE && last_chunk && grp == 3'd6) begin
      chk_err <= (s_next != ref_sum);
    end
  end
`endif

  assign lp.in_ready  = (state == IDLE);
  assign lp.out_valid = (state == DONE);
  assign lp.s         = s_reg;
  assign lp.cy        = cy_reg;

endmodule

// File: tb/tb_gen_linear_part.sv
// Scoreboard bench for gen_linear_part: golden carries/sum from an a+b ripple model,
// term vectors synthesised with the right group parities (random filler or minimal).
module tb_gen_linear_part;

  localparam int CHUNK = 32;

  typedef struct {
    logic [7:0] s;
    logic [6:0] cy;
    logic       chk;
  } exp_t;

  logic clk;
  logic rst_n;
`ifdef LINEAR_PART_CHECK_EN
  logic chk_err;
`endif

  gen_linear_part_if lp ();

  gen_linear_part #(.CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .lp    (lp)
`ifdef LINEAR_PART_CHECK_EN
    ,
    .chk_err (chk_err)
`endif
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] model_cy(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 7; i++) c[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
    return c[7:1];
  endfunction

  // Group i's parity must equal carry c(i+1); the first bit of each group absorbs the filler.
  function automatic logic [500:0] make_n(input logic [7:0] a, input logic [7:0] b, input bit rnd);
    logic [500:0] v;
    logic [6:0]   c;
    logic         par;
    int           start;
    int           size;
    v = '0;
    c = model_cy(a, b);
    start = 0;
    for (int i = 0; i < 7; i++) begin
      size = (1 << (i + 2)) - 1;
      par  = 1'b0;
      for (int k = 1; k < size; k++) begin
        v[start+k] = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        par = par ^ v[start+k];
      end
      v[start] = par ^ c[i];
      start += size;
    end
    return v;
  endfunction

  function automatic int exp_latency();
    int l;
    int size;
    l = 0;
    for (int i = 0; i < 7; i++) begin
      size = (1 << (i + 2)) - 1;
      l += (size + CHUNK - 1) / CHUNK;
    end
    return l;
  endfunction

  task automatic drive_capture(input logic [7:0] a, input logic [7:0] b, input logic [500:0] n);
    int w;
    w = 0;
    while (!lp.in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (!lp.in_ready) checkOutput("in_ready_timeout", 32'(lp.in_ready), 32'd1);
    lp.a = a;
    lp.b = b;
    lp.n = n;
    lp.in_valid = 1'b1;
    @(posedge clk); #1;
    lp.in_valid = 1'b0;
    lp.a = 8'($urandom);
    lp.b = 8'($urandom);
    lp.n = 501'({16{$urandom()}});
    checkOutput("in_ready_busy", 32'(lp.in_ready), 32'd0);
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [500:0] n, input exp_t e);
    int cnt;
    sb.push_back(e);
    drive_capture(a, b, n);
    cnt = 0;
    while (!lp.out_valid && cnt < 2000) begin
      @(posedge clk); #1;
      cnt++;
    end
    checkOutput("latency", 32'(cnt), 32'(exp_latency()));
    if (lp.out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input bit rnd);
    exp_t e;
    e.s   = a + b;
    e.cy  = model_cy(a, b);
    e.chk = 1'b0;
    applyStimulus(a, b, make_n(a, b, rnd), e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && lp.out_valid && lp.out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("sb_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("s", 32'(lp.s), 32'(e.s));
        checkOutput("cy", 32'(lp.cy), 32'(e.cy));
`ifdef LINEAR_PART_CHECK_EN
        checkOutput("chk_err", 32'(chk_err), 32'(e.chk));
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t         e;
    logic [500:0] nv;
    logic [7:0]   ra;
    logic [7:0]   rb;

    rst_n = 1'b1;
    lp.in_valid = 1'b0;
    lp.out_ready = 1'b1;
    lp.a = '0;
    lp.b = '0;
    lp.n = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(lp.in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(lp.out_valid), 32'd0);
    checkOutput("rst_s", 32'(lp.s), 32'd0);
    checkOutput("rst_cy", 32'(lp.cy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn(8'h00, 8'h00, 1'b0);
    run_txn(8'hFF, 8'h01, 1'b1);
    run_txn(8'h5A, 8'hA5, 1'b1);
    run_txn(8'hFF, 8'hFF, 1'b1);

    // Back-pressure: result must hold and further in_valid must be ignored.
    lp.out_ready = 1'b0;
    run_txn(8'h12, 8'h34, 1'b1);
    lp.in_valid = 1'b1;
    lp.a = 8'hEE;
    lp.b = 8'h77;
    lp.n = make_n(8'hEE, 8'h77, 1'b1);
    repeat (10) begin
      @(posedge clk); #1;
      checkOutput("bp_s", 32'(lp.s), 32'h46);
      checkOutput("bp_cy", 32'(lp.cy), 32'(model_cy(8'h12, 8'h34)));
      checkOutput("bp_in_ready", 32'(lp.in_ready), 32'd0);
      checkOutput("bp_out_valid", 32'(lp.out_valid), 32'd1);
    end
    lp.in_valid = 1'b0;
    lp.out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release_in_ready", 32'(lp.in_ready), 32'd1);
    checkOutput("bp_release_out_valid", 32'(lp.out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("bp_no_capture", 32'(lp.in_ready), 32'd1);

    // Reset in the middle of REDUCE discards the partial result.
    drive_capture(8'hFF, 8'h01, make_n(8'hFF, 8'h01, 1'b1));
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(lp.out_valid), 32'd0);
    checkOutput("midrst_s", 32'(lp.s), 32'd0);
    checkOutput("midrst_cy", 32'(lp.cy), 32'd0);
    checkOutput("midrst_in_ready", 32'(lp.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(8'h03, 8'h05, 1'b1);

`ifdef LINEAR_PART_CHECK_EN
    nv = make_n(8'h01, 8'h01, 1'b0);
    nv[0] = ~nv[0];
    e.s   = 8'h00;
    e.cy  = 7'h00;
    e.chk = 1'b1;
    applyStimulus(8'h01, 8'h01, nv, e);
    run_txn(8'h01, 8'h01, 1'b0);
`endif

    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_txn(ra, rb, 1'b1);
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
